// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;
    localparam int N_RD_DEF   = 2;

    // Bit offset of a read port's field inside a packed per-port bus.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register.
// An issue sets the bit. A writeback clears it. Issue wins when both target the same register.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int HOLD_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next state per bit: set on issue, else clear on writeback, else hold.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_en && iss_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (clr_en && clr_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
        end
        if (HOLD_ZERO != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Scoreboard state register; reset drops every pending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two write ports, N_RD combinational read ports,
// optional write-to-read bypass, optional hard-wired zero register,
// and a busy scoreboard.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = N_RD_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next register contents: port B is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (wa_en) begin
            mem_d[wa_addr] = wa_data;
        end
        if (wb_en) begin
            mem_d[wb_addr] = wb_data;
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    // Register storage; needs a full clear on reset, so it is flops rather than RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    reg_scoreboard #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .HOLD_ZERO (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (wa_en),
        .clr_addr (wa_addr),
        .busy_vec (busy_vec)
    );

    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];

        // Read mux: port B bypass, then port A bypass, then stored value.
        // The zero register overrides all of them.
        always_comb begin
            data = mem_q[addr];
            if (BYPASS != 0) begin
                if (wb_en && wb_addr == addr) begin
                    data = wb_data;
                end else if (wa_en && wa_addr == addr) begin
                    data = wa_data;
                end
            end
            if (ZERO_REG != 0 && addr == '0) begin
                data = '0;
            end
        end

        assign rd_data[port_lsb(gi, DATA_W) +: DATA_W] = data;
        // Busy comes from registered scoreboard state only.
        assign rd_busy[gi] = busy_vec[addr];
    end

endmodule
